interp_line_wr_ctrl: RTL
========================

Name: interp_line_wr_ctrl

Overview:
Write-side controller for the interpolation line buffers. Accepts a raster pixel stream (16-bit RGB565 plus DE/VS) and writes each active line into one of four 2048x16 simple-dual-port line RAMs. The four RAMs are used as a rotating ring. After each line is written, the block hands the filled bank to the downstream bilinear reader through a ready/release handshake. Sits between the video input capture and the interpolation RAM bank.

Parameters:
DATA_W, 16, pixel width; equals RAM write width
ADDR_W, 11, RAM address width
LINE_MAX, 2048, maximum pixels stored per line; must be <= 2**ADDR_W
NUM_BANKS, 4, line RAMs in the ring; fixed at 4 (2-bit bank index)

Ports:
clk  in  1  pixel clock; also the RAM wr_clk
rst  in  1  synchronous, active-high reset
in_vs  in  1  vertical sync, active-high level
in_de  in  1  data enable, active-high
in_data  in  DATA_W  pixel
ram_wr_data  out  DATA_W  shared write data to all banks
ram_wr_addr  out  ADDR_W  shared write address
ram_wr_en  out  NUM_BANKS  one-hot bank write enable
line_rdy  out  1  one-cycle pulse: a line is complete in line_bank
line_bank  out  2  bank index of the completed line
line_len  out  ADDR_W+1  pixel count of the completed line (1..LINE_MAX)
line_idx  out  12  line number within the frame, from 0
frame_start  out  1  one-cycle pulse on VS rising edge
rel_vld  in  1  reader releases a bank
rel_bank  in  2  bank being released
overflow  out  1  sticky: a line was dropped because no bank was free; cleared by rst or frame_start
drop_cnt  out  16  dropped-line counter (see Optional Feature)

Behaviour:
- Reset values:
  - All outputs 0.
  - All banks free.
  - wr_ptr = 0.
  - line_idx = 0.
  - State IDLE.
- Edge detection:
  - in_vs and in_de are registered once internally.
  - Rising and falling edges are detected against the registered copy.
- States:
  - IDLE: waiting for a line.
  - WRITE: storing the current line.
  - DROP: discarding the current line.
- IDLE -> on DE rising edge:
  - If bank wr_ptr is free: mark it busy, go to WRITE, col = 0.
  - If bank wr_ptr is busy: go to DROP, set overflow, increment drop_cnt.
  - Banks are claimed strictly in ring order so the reader can rely on sequence.
- WRITE:
  - Each cycle in_de = 1 and col < LINE_MAX: write in_data to bank wr_ptr at address col, then col++.
  - Write port is registered: ram_wr_* change 1 cycle after the in_* sample.
  - Pixels beyond LINE_MAX are ignored and col saturates.
- WRITE -> IDLE on DE falling edge:
  - The cycle after the last RAM write, pulse line_rdy with line_bank = wr_ptr, line_len = col, line_idx.
  - Then wr_ptr++ (mod 4) and line_idx++.
  - line_bank, line_len and line_idx hold until the next line_rdy.
- DROP -> IDLE on DE falling edge:
  - No line_rdy, and line_idx still increments.
- Release handling:
  - rel_vld frees rel_bank.
  - Releasing an already-free bank is ignored.
  - If a release and a claim of the same bank occur in the same cycle, the release is applied first and the claim succeeds.
- VS rising edge (has priority over everything else):
  - Pulse frame_start.
  - line_idx = 0, wr_ptr = 0.
  - All banks forced free, overflow cleared.
  - Any WRITE/DROP in progress is aborted with no line_rdy; go to IDLE.
  - The reader must discard outstanding banks on frame_start.
- Line length arithmetic: line_len is ADDR_W+1 bits so LINE_MAX = 2048 is representable. A zero-length line cannot occur, because DE is high for at least one cycle.
- Synchronous rst mid-line: aborts immediately, all state returns to reset values, and no write is issued in the reset cycle.

Optional Feature:
Macro INTERP_WR_DROP_CNT_EN.
- Defined: drop_cnt is a 16-bit saturating counter of dropped lines. It clears on rst only, not on frame_start.
- Undefined: drop_cnt is tied to 0 and the counter logic is removed; overflow behaves identically in both cases.

Decomposition:
- Shared package interp_pkg holds:
  - DATA_W, ADDR_W, LINE_MAX, NUM_BANKS.
  - bank_idx_t (2-bit) type.
  - wr_state_t enum {IDLE, WRITE, DROP}.
- The reader block reuses interp_pkg.
- One sub-module: interp_bank_alloc, which holds the 4 busy flags and implements claim/release/clear-all with release-before-claim priority.

Test Plan:
- Line write, data and timing:
  - Stimulus: VS pulse, then DE high 640 cycles with in_data = column index.
  - Required: bank 0 receives addresses 0..639 with matching data, each write 1 cycle after its input sample.
  - Required: line_rdy pulses once with bank = 0, len = 640, idx = 0.
- Bank exhaustion:
  - Stimulus: 5 lines of 100 pixels with no releases.
  - Required: banks 0,1,2,3 filled; 5th line dropped; overflow = 1; drop_cnt = 1 (macro on); line_idx of the next accepted line is 5.
- Release/claim collision:
  - Stimulus: all 4 banks busy, then rel_vld with rel_bank = 0 in the same cycle as a DE rising edge.
  - Required: the line is written to bank 0 and no overflow occurs.
- Over-length line:
  - Stimulus: DE high for 2100 cycles.
  - Required: writes stop at address 2047 and line_len = 2048.
- VS mid-line abort:
  - Stimulus: VS rises at pixel 300 of a line.
  - Required: no line_rdy, frame_start pulses, next line goes to bank 0 with idx 0, overflow cleared.
- Reset mid-line:
  - Stimulus: rst at pixel 50.
  - Required: ram_wr_en = 0 from the reset cycle onward, all outputs 0, and the next line goes to bank 0.

Source files
------------

// File: rtl/interp_pkg.sv
// Shared types and sizing for the interpolation line-buffer write and read sides.
// Both sides import this package so bank indices and state types stay aligned.
package interp_pkg;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 11;
    localparam int LINE_MAX  = 2048;
    localparam int NUM_BANKS = 4;

    localparam logic [ADDR_W:0] COL_MAX = (ADDR_W+1)'(LINE_MAX);

    typedef logic [1:0] bank_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        DROP
    } wr_state_t;

endpackage

// File: rtl/interp_line_wr_ctrl_if.sv
// Line RAM write port plus the line-ready / bank-release handshake
// between the write controller (master) and the reader/RAM side (slave).
interface interp_line_wr_ctrl_if;
    import interp_pkg::*;

    logic [DATA_W-1:0]    ram_wr_data;
    logic [ADDR_W-1:0]    ram_wr_addr;
    logic [NUM_BANKS-1:0] ram_wr_en;
    logic                 line_rdy;
    bank_idx_t            line_bank;
    logic [ADDR_W:0]      line_len;
    logic [11:0]          line_idx;
    logic                 frame_start;
    logic                 rel_vld;
    bank_idx_t            rel_bank;

    modport master (
        output ram_wr_data, ram_wr_addr, ram_wr_en,
        output line_rdy, line_bank, line_len, line_idx,
        output frame_start,
        input  rel_vld, rel_bank
    );

    modport slave (
        input  ram_wr_data, ram_wr_addr, ram_wr_en,
        input  line_rdy, line_bank, line_len, line_idx,
        input  frame_start,
        output rel_vld, rel_bank
    );

endinterface

// File: rtl/interp_bank_alloc.sv
// Busy flags for the four line banks: release, then claim, with clear-all overriding both.
// claim_ok already accounts for a same-cycle release of the requested bank.
module interp_bank_alloc
    import interp_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      clr_all,
    input  logic      rel_vld,
    input  bank_idx_t rel_bank,
    input  logic      claim,
    input  bank_idx_t claim_bank,
    output logic      claim_ok
);

    logic [NUM_BANKS-1:0] busy_q, busy_d, busy_rel;

    always_comb begin
        busy_rel = busy_q;
        if (rel_vld) busy_rel[rel_bank] = 1'b0;
        claim_ok = ~busy_rel[claim_bank];
        busy_d = busy_rel;
        if (claim && claim_ok) busy_d[claim_bank] = 1'b1;
        if (clr_all) busy_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

endmodule

// File: rtl/interp_line_wr_ctrl.sv
// Writes active raster lines into a 4-bank ring of line RAMs and hands each filled bank to the reader.
// Define INTERP_WR_DROP_CNT_EN to build the saturating dropped-line counter on drop_cnt.
module interp_line_wr_ctrl
    import interp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vs,
    input  logic                 in_de,
    input  logic [DATA_W-1:0]    in_data,
    interp_line_wr_ctrl_if.master lb,
    output logic                 overflow,
    output logic [15:0]          drop_cnt
);

    logic                 vs_q, vs_d, de_q, de_d;
    wr_state_t            state_q, state_d;
    logic [ADDR_W:0]      col_q, col_d;
    bank_idx_t            wr_ptr_q, wr_ptr_d;
    logic [11:0]          idx_q, idx_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
    logic [NUM_BANKS-1:0] wr_en_q, wr_en_d;
    logic                 rdy_q, rdy_d;
    bank_idx_t            bank_q, bank_d;
    logic [ADDR_W:0]      len_q, len_d;
    logic [11:0]          lidx_q, lidx_d;
    logic                 fs_q, fs_d;
    logic                 ovf_q, ovf_d;
    logic                 vs_rise, de_rise, de_fall;
    logic                 claim, claim_ok, clr_all, drop_inc;

    assign vs_rise = in_vs & ~vs_q;
    assign de_rise = in_de & ~de_q;
    assign de_fall = ~in_de & de_q;

    interp_bank_alloc u_alloc (
        .clk        (clk),
        .rst        (rst),
        .clr_all    (clr_all),
        .rel_vld    (lb.rel_vld),
        .rel_bank   (lb.rel_bank),
        .claim      (claim),
        .claim_bank (wr_ptr_q),
        .claim_ok   (claim_ok)
    );

    always_comb begin
        vs_d      = in_vs;
        de_d      = in_de;
        state_d   = state_q;
        col_d     = col_q;
        wr_ptr_d  = wr_ptr_q;
        idx_d     = idx_q;
        wr_data_d = wr_data_q;
        wr_addr_d = wr_addr_q;
        wr_en_d   = '0;
        rdy_d     = 1'b0;
        bank_d    = bank_q;
        len_d     = len_q;
        lidx_d    = lidx_q;
        fs_d      = 1'b0;
        ovf_d     = ovf_q;
        claim     = 1'b0;
        clr_all   = 1'b0;
        drop_inc  = 1'b0;
        // Frame sync overrides any line activity in the same cycle
        if (vs_rise) begin
            fs_d     = 1'b1;
            idx_d    = '0;
            wr_ptr_d = '0;
            clr_all  = 1'b1;
            ovf_d    = 1'b0;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (de_rise) begin
                        claim = 1'b1;
                        if (claim_ok) begin
                            state_d           = WRITE;
                            wr_en_d[wr_ptr_q] = 1'b1;
                            wr_addr_d         = '0;
                            wr_data_d         = in_data;
                            col_d             = (ADDR_W+1)'(1);
                        end else begin
                            state_d  = DROP;
                            ovf_d    = 1'b1;
                            drop_inc = 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (de_fall) begin
                        rdy_d    = 1'b1;
                        bank_d   = wr_ptr_q;
                        len_d    = col_q;
                        lidx_d   = idx_q;
                        wr_ptr_d = wr_ptr_q + 2'd1;
                        idx_d    = idx_q + 12'd1;
                        state_d  = IDLE;
                    end else if (in_de && col_q < COL_MAX) begin
                        wr_en_d[wr_ptr_q] = 1'b1;
                        wr_addr_d         = col_q[ADDR_W-1:0];
                        wr_data_d         = in_data;
                        col_d             = col_q + 1'b1;
                    end
                end
                DROP: begin
                    if (de_fall) begin
                        idx_d   = idx_q + 12'd1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q      <= 1'b0;
            de_q      <= 1'b0;
            state_q   <= IDLE;
            col_q     <= '0;
            wr_ptr_q  <= '0;
            idx_q     <= '0;
            wr_data_q <= '0;
            wr_addr_q <= '0;
            wr_en_q   <= '0;
            rdy_q     <= 1'b0;
            bank_q    <= '0;
            len_q     <= '0;
            lidx_q    <= '0;
            fs_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            vs_q      <= vs_d;
            de_q      <= de_d;
            state_q   <= state_d;
            col_q     <= col_d;
            wr_ptr_q  <= wr_ptr_d;
            idx_q     <= idx_d;
            wr_data_q <= wr_data_d;
            wr_addr_q <= wr_addr_d;
            wr_en_q   <= wr_en_d;
            rdy_q     <= rdy_d;
            bank_q    <= bank_d;
            len_q     <= len_d;
            lidx_q    <= lidx_d;
            fs_q      <= fs_d;
            ovf_q     <= ovf_d;
        end
    end

`ifdef INTERP_WR_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign drop_cnt = '0;
`endif

    assign lb.ram_wr_data = wr_data_q;
    assign lb.ram_wr_addr = wr_addr_q;
    assign lb.ram_wr_en   = wr_en_q;
    assign lb.line_rdy    = rdy_q;
    assign lb.line_bank   = bank_q;
    assign lb.line_len    = len_q;
    assign lb.line_idx    = lidx_q;
    assign lb.frame_start = fs_q;
    assign overflow       = ovf_q;

endmodule
